// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle main FSM and the MIPS datapath.
// The controller takes the master view; the datapath side takes the slave view.
interface mc_controller_if;
    logic [5:0] op;
    logic       zero;
    logic       memReady;

    logic       memWrite;
    logic       irWrite;
    logic       iorD;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       pcWrite;
    logic       branch;
    logic       pcEn;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, zero, memReady,
        output memWrite, irWrite, iorD, aluSrcA, aluSrcB, aluOp, pcSrc,
               regDst, memToReg, regWrite, pcWrite, branch, pcEn, illegal, state
    );

    modport slave (
        output op, zero, memReady,
        input  memWrite, irWrite, iorD, aluSrcA, aluSrcB, aluOp, pcSrc,
               regDst, memToReg, regWrite, pcWrite, branch, pcEn, illegal, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory port, stalling on memReady.
module mc_controller (
    input  logic                clk,
    input  logic                rst_n,
    mc_controller_if.master     bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q;
    state_t     state_d;

    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       branch_q;
    logic       illegal_op;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = FETCH;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        pc_write     = 1'b0;
        branch_q     = 1'b0;
        illegal_op   = 1'b0;
        bus.iorD     = 1'b0;
        bus.aluSrcA  = 1'b0;
        bus.aluSrcB  = 2'b00;
        bus.aluOp    = 2'b00;
        bus.pcSrc    = 2'b00;
        bus.regDst   = 1'b0;
        bus.memToReg = 1'b0;

        case (state_q)
            FETCH: begin
                bus.aluSrcB = 2'b01;
                // IR load and PC+4 happen only on the cycle memory delivers the word
                ir_write    = bus.memReady;
                pc_write    = bus.memReady;
                state_d     = bus.memReady ? DECODE : FETCH;
            end
            DECODE: begin
                bus.aluSrcB = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
                if (bus.op == OP_LW) begin
                    state_d = MEMREAD;
                end else if (bus.op == OP_SW) begin
                    state_d = MEMWRITE;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMREAD: begin
                bus.iorD = 1'b1;
                state_d  = bus.memReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                bus.memToReg = 1'b1;
                reg_write    = 1'b1;
            end
            MEMWRITE: begin
                bus.iorD  = 1'b1;
                mem_write = 1'b1;
                state_d   = bus.memReady ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                bus.aluSrcA = 1'b1;
                bus.aluOp   = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                bus.regDst = 1'b1;
                reg_write  = 1'b1;
            end
            BRANCH: begin
                bus.aluSrcA = 1'b1;
                bus.aluOp   = 2'b01;
                bus.pcSrc   = 2'b01;
                branch_q    = 1'b1;
            end
            ADDIEXEC: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
                state_d     = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                bus.pcSrc = 2'b10;
                pc_write  = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Strobes are gated by reset so a held reset never writes state anywhere
    assign bus.memWrite = rst_n & mem_write;
    assign bus.irWrite  = rst_n & ir_write;
    assign bus.regWrite = rst_n & reg_write;
    assign bus.pcWrite  = rst_n & pc_write;
    assign bus.branch   = rst_n & branch_q;
    assign bus.illegal  = rst_n & illegal_op;
    assign bus.pcEn     = rst_n & (pc_write | (branch_q & bus.zero));
    assign bus.state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction cycle scripts give the
// expected state and control word each cycle; a few literal pins anchor the scripts.
module tb_mc_controller;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        bit          rst;
        bit          mr;
        bit          z;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [16:0] ctl;
        bit          pin;
        logic [3:0]  pst;
        string       pf;
        logic [1:0]  pv;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    mc_controller_if bus();

    mc_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    step_t plan[$];
    step_t cur;
    bit    cur_valid = 1'b0;
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    // Control word: {memWrite, irWrite, iorD, aluSrcA, aluSrcB, aluOp, pcSrc,
    //                regDst, memToReg, regWrite, pcWrite, branch, pcEn, illegal}
    function automatic logic [16:0] cw(input bit mw = 0, input bit irw = 0, input bit iord = 0,
                                       input bit srca = 0, input logic [1:0] srcb = 2'b00,
                                       input logic [1:0] aop = 2'b00, input logic [1:0] psrc = 2'b00,
                                       input bit rdst = 0, input bit m2r = 0, input bit rw = 0,
                                       input bit pw = 0, input bit br = 0, input bit z = 0,
                                       input bit ill = 0);
        bit pcen;
        pcen = pw | (br & z);
        return {mw, irw, iord, srca, srcb, aop, psrc, rdst, m2r, rw, pw, br, pcen, ill};
    endfunction

    task automatic add(input bit rst, input logic [5:0] op, input bit mr, input bit z,
                       input logic [3:0] st, input logic [16:0] ctl);
        step_t s;
        s.rst = rst; s.mr = mr; s.z = z; s.op = op; s.st = st; s.ctl = ctl;
        s.pin = 1'b0; s.pst = 4'd0; s.pf = ""; s.pv = 2'b00;
        plan.push_back(s);
    endtask

    task automatic pin(input int idx, input logic [3:0] s, input string f, input logic [1:0] v);
        plan[idx].pin = 1'b1;
        plan[idx].pst = s;
        plan[idx].pf  = f;
        plan[idx].pv  = v;
    endtask

    // One instruction from FETCH up to (not including) the next FETCH.
    task automatic build(input logic [5:0] op, input bit z, input int unsigned fwait,
                         input int unsigned mwait);
        bit bad;
        bad = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
        for (int unsigned i = 0; i < fwait; i++) add(0, op, 0, z, 4'd0, cw(.srcb(2'b01)));
        add(0, op, 1, z, 4'd0, cw(.irw(1), .pw(1), .srcb(2'b01)));
        add(0, op, 0, z, 4'd1, cw(.srcb(2'b11), .ill(bad)));
        case (op)
            OP_LW: begin
                add(0, op, 0, z, 4'd2, cw(.srca(1), .srcb(2'b10)));
                for (int unsigned i = 0; i < mwait; i++) add(0, op, 0, z, 4'd3, cw(.iord(1)));
                add(0, op, 1, z, 4'd3, cw(.iord(1)));
                add(0, op, 0, z, 4'd4, cw(.m2r(1), .rw(1)));
            end
            OP_SW: begin
                add(0, op, 1, z, 4'd2, cw(.srca(1), .srcb(2'b10)));
                for (int unsigned i = 0; i < mwait; i++) add(0, op, 0, z, 4'd5, cw(.mw(1), .iord(1)));
                add(0, op, 1, z, 4'd5, cw(.mw(1), .iord(1)));
            end
            OP_R: begin
                add(0, op, 1, z, 4'd6, cw(.srca(1), .aop(2'b10)));
                add(0, op, 0, z, 4'd7, cw(.rdst(1), .rw(1)));
            end
            OP_BEQ:  add(0, op, 1, z, 4'd8, cw(.srca(1), .aop(2'b01), .psrc(2'b01), .br(1), .z(z)));
            OP_ADDI: begin
                add(0, op, 0, z, 4'd9, cw(.srca(1), .srcb(2'b10)));
                add(0, op, 1, z, 4'd10, cw(.rw(1)));
            end
            OP_J:    add(0, op, 0, z, 4'd11, cw(.psrc(2'b10), .pw(1)));
            default: ;
        endcase
    endtask

    function automatic logic [1:0] obs(input string f);
        case (f)
            "irWrite":  return {1'b0, bus.irWrite};
            "memWrite": return {1'b0, bus.memWrite};
            "iorD":     return {1'b0, bus.iorD};
            "regWrite": return {1'b0, bus.regWrite};
            "pcEn":     return {1'b0, bus.pcEn};
            "illegal":  return {1'b0, bus.illegal};
            "aluSrcB":  return bus.aluSrcB;
            "aluOp":    return bus.aluOp;
            "pcSrc":    return bus.pcSrc;
            default:    return 2'bxx;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [16:0] act;
        if (cur_valid) begin
            cyc = cyc + 1;
            act = {bus.memWrite, bus.irWrite, bus.iorD, bus.aluSrcA, bus.aluSrcB, bus.aluOp,
                   bus.pcSrc, bus.regDst, bus.memToReg, bus.regWrite, bus.pcWrite,
                   bus.branch, bus.pcEn, bus.illegal};
            checks = checks + 1;
            if (bus.state !== cur.st || act !== cur.ctl) begin
                errors = errors + 1;
                $display("FAIL model cyc%0d: state=%0d ctl=%05h required state=%0d ctl=%05h",
                         cyc, bus.state, act, cur.st, cur.ctl);
            end
            if (cur.pin) begin
                checks = checks + 1;
                if (bus.state !== cur.pst || obs(cur.pf) !== cur.pv) begin
                    errors = errors + 1;
                    $display("FAIL pin %s cyc%0d: state=%0d value=%0d required state=%0d value=%0d",
                             cur.pf, cyc, bus.state, obs(cur.pf), cur.pst, cur.pv);
                end
            end
        end
    end

    initial begin
        int base;
        bus.op = OP_LW;
        bus.zero = 1'b0;
        bus.memReady = 1'b1;

        // Reset held three checked cycles with memReady=1.
        for (int i = 0; i < 3; i++) add(1, OP_LW, 1, 0, 4'd0, cw(.srcb(2'b01)));
        pin(0, 4'd0, "irWrite", 2'd0);
        pin(2, 4'd0, "pcEn", 2'd0);

        base = plan.size();
        build(OP_LW, 0, 0, 0);
        pin(base + 0, 4'd0, "irWrite", 2'd1);
        pin(base + 1, 4'd1, "aluSrcB", 2'd3);
        pin(base + 2, 4'd2, "aluSrcB", 2'd2);
        pin(base + 3, 4'd3, "iorD", 2'd1);
        pin(base + 4, 4'd4, "regWrite", 2'd1);

        base = plan.size();
        build(OP_SW, 0, 0, 3);
        pin(base + 0, 4'd0, "irWrite", 2'd1);
        for (int i = 3; i < 7; i++) pin(base + i, 4'd5, "memWrite", 2'd1);

        base = plan.size();
        build(OP_BEQ, 1, 0, 0);
        pin(base + 2, 4'd8, "pcEn", 2'd1);
        base = plan.size();
        build(OP_BEQ, 0, 0, 0);
        pin(base + 2, 4'd8, "pcEn", 2'd0);

        base = plan.size();
        build(OP_R, 1, 0, 0);
        pin(base + 2, 4'd6, "aluOp", 2'd2);
        pin(base + 3, 4'd7, "regWrite", 2'd1);

        base = plan.size();
        build(OP_J, 1, 0, 0);
        pin(base + 0, 4'd0, "irWrite", 2'd1);
        pin(base + 2, 4'd11, "pcSrc", 2'd2);

        base = plan.size();
        build(OP_BAD, 0, 0, 0);
        pin(base + 0, 4'd0, "illegal", 2'd0);
        pin(base + 1, 4'd1, "illegal", 2'd1);

        base = plan.size();
        build(OP_ADDI, 0, 2, 0);
        pin(base + 0, 4'd0, "irWrite", 2'd0);
        pin(base + 1, 4'd0, "irWrite", 2'd0);
        pin(base + 2, 4'd0, "irWrite", 2'd1);
        pin(base + 4, 4'd9, "aluSrcB", 2'd2);
        pin(base + 5, 4'd10, "regWrite", 2'd1);

        // Reset during a lw memory wait: abandoned, next cycle is FETCH.
        base = plan.size();
        build(OP_LW, 0, 0, 2);
        plan[base + 4].rst = 1'b1;
        while (plan.size() > base + 5) void'(plan.pop_back());
        base = plan.size();
        build(OP_SW, 0, 0, 0);
        pin(base + 0, 4'd0, "irWrite", 2'd1);

        // Reset during ALUWB: regWrite must be suppressed.
        base = plan.size();
        build(OP_R, 0, 0, 0);
        plan[base + 3].rst = 1'b1;
        plan[base + 3].ctl = cw(.rdst(1));
        pin(base + 3, 4'd7, "regWrite", 2'd0);

        base = plan.size();
        add(0, OP_LW, 0, 0, 4'd0, cw(.srcb(2'b01)));
        pin(base, 4'd0, "irWrite", 2'd0);

        @(posedge clk);
        foreach (plan[i]) begin
            #1;
            rst_n        = !plan[i].rst;
            bus.memReady = plan[i].mr;
            bus.zero     = plan[i].z;
            bus.op       = plan[i].op;
            cur          = plan[i];
            cur_valid    = 1'b1;
            @(posedge clk);
        end
        #1 cur_valid = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle main control FSM for the MIPS core. It sequences one shared ALU, one unified instruction/data memory port and the register file across fetch, decode, execute, memory and writeback steps. It drives the 2-bit ALU-op code consumed by the ALU decoder, and stalls on a memory-ready handshake.

## Interface
Parameters:
- none; opcodes are fixed: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset: one clock; reset is synchronous and active-low
- op  in  6  opcode field from instruction register, stable from DECODE until next FETCH
- zero  in  1  ALU zero flag
- memReady  in  1  memory completes current access this cycle
- memWrite  out  1  memory write strobe
- irWrite  out  1  instruction register load
- iorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- aluSrcA  out  1  0 = PC, 1 = register A
- aluSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- aluOp  out  2  00 add, 01 sub, 10 use funct
- pcSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- regDst  out  1  1 = rd, 0 = rt
- memToReg  out  1  1 = memory data, 0 = ALUOut
- regWrite  out  1  register file write
- pcWrite  out  1  unconditional PC write
- branch  out  1  conditional branch qualifier
- pcEn  out  1  pcWrite | (branch & zero)
- illegal  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state encoding, for debug and verification

## Operation
- States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Encodings 12-15 are unreachable and go to FETCH next cycle with all strobes 0.
- Output defaults: all strobes 0; muxes 0 (aluSrcB=00, aluOp=00, pcSrc=00) unless listed below.
- FETCH: iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00. irWrite=pcWrite=memReady (Mealy). Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state by op:
  - lw or sw -> MEMADR
  - R-type -> EXECUTE
  - beq -> BRANCH
  - addi -> ADDIEXEC
  - j -> JUMP
  - any other op -> FETCH, with illegal=1 this cycle
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: iorD=1. Holds until memReady=1, then goes to MEMWB.
- MEMWB: regDst=0, memToReg=1, regWrite=1 -> FETCH.
- MEMWRITE: iorD=1, memWrite=1, held every cycle in this state. Goes to FETCH on memReady=1.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10 -> ALUWB.
- ALUWB: regDst=1, memToReg=0, regWrite=1 -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, branch=1 -> FETCH.
- ADDIEXEC: aluSrcA=1, aluSrcB=10, aluOp=00 -> ADDIWB.
- ADDIWB: regDst=0, memToReg=0, regWrite=1 -> FETCH.
- JUMP: pcSrc=10, pcWrite=1 -> FETCH.
- memReady is ignored outside FETCH, MEMREAD and MEMWRITE.

## Timing
- Reset: when rst_n=0 at a clock edge, state becomes FETCH. While rst_n=0, the strobes memWrite, irWrite, regWrite, pcWrite, pcEn, branch and illegal are forced to 0 combinationally. Reset mid-instruction abandons it; no writeback occurs.
- After rst_n deasserts, the first FETCH cycle may assert irWrite/pcWrite if memReady=1.
- Latency in cycles with zero wait states, FETCH through the return to FETCH:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2
  - each cycle with memReady=0 in FETCH, MEMREAD or MEMWRITE adds 1
- pcEn is combinational from the current state and zero, with no registered delay. In BRANCH, pcEn equals zero in the same cycle.
- Regs/PC/IR update at the edge ending the cycle in which the strobe is high. Exactly one regWrite cycle per lw/R-type/addi; none for others.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with memReady=1 -> state=0 and all strobes 0 throughout; the first cycle after release has irWrite=pcWrite=1.
- lw, memReady always 1 -> state sequence 0,1,2,3,4,0. In state 2, aluSrcB=10 and aluOp=00. In state 4, regWrite=1 and memToReg=1.
- sw with memReady=0 for 3 cycles in MEMWRITE -> memWrite=1 and iorD=1 for 4 consecutive cycles, then state=0; regWrite never asserted.
- beq with zero=1, then zero=0 -> in BRANCH, aluOp=01 and pcSrc=01; pcEn=1 for the first, pcEn=0 for the second.
- R-type then j -> R-type: EXECUTE has aluOp=10, ALUWB has regDst=1 and regWrite=1. j: JUMP has pcSrc=10 and pcEn=1, 3 cycles total.
- op=111111 in DECODE -> illegal=1 for exactly one cycle, then state=0. Separately, fetch stall with memReady=0 for 2 cycles -> irWrite stays 0 until the memReady=1 cycle.
